pulse_symbol_engine: RTL
========================

PULSE_SYMBOL_ENGINE -- requirements
Module: pulse_symbol_engine

Interface
REQ-001 SHALL have parameter DUR_W, default 8: symbol duration field width.
REQ-002 SHALL have parameter PRE_W, default 4: prescaler field width.
REQ-003 SHALL have clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have sys_rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have en  input  1: engine enable; low aborts and holds idle.
REQ-006 SHALL have prescale  input  PRE_W: unit length in clocks = prescale+1.
REQ-007 SHALL have idle_level  input  1: output level when no symbol is active.
REQ-008 SHALL have sym_valid  input  1: upstream symbol offered.
REQ-009 SHALL have sym_level  input  1: symbol output level.
REQ-010 SHALL have sym_dur  input  DUR_W: symbol length in units = sym_dur+1.
REQ-011 SHALL have sym_ready  output  1: symbol accepted when sym_valid && sym_ready at an edge.
REQ-012 SHALL have sig_out  output  1: registered pulse stream, fed directly to the downstream 1-cycle delay stage.
REQ-013 SHALL have busy  output  1: a symbol is currently being emitted.
REQ-014 SHALL have done  output  1: one-cycle pulse when the last queued symbol finishes.

Function
REQ-015 SHALL hold a one-entry symbol buffer (level, dur); sym_ready = en && buffer empty (combinational).
REQ-016 SHALL implement states IDLE and RUN; IDLE->RUN when buffer full, RUN->IDLE at symbol end with buffer empty, RUN->RUN (reload) at symbol end with buffer full.
REQ-017 SHALL, on load, latch level, dur and prescale; prescale changes mid-symbol SHALL take effect only at the next load.
REQ-018 SHALL, for a handshake at edge N with engine IDLE, load at edge N+1; sig_out equals sym_level from edge N+1.
REQ-019 SHALL hold each symbol on sig_out for exactly (dur+1)*(prescale+1) clocks.
REQ-020 SHALL emit back-to-back symbols with zero gap cycles when the next symbol is buffered before the current one ends.
REQ-021 SHALL, if the buffer is written on the same edge the current symbol ends, treat it as buffer empty at that edge (IDLE entered) and load at the following edge.
REQ-022 SHALL, at the end edge with buffer empty, drive sig_out = idle_level, busy = 0 and done = 1 for exactly one cycle.
REQ-023 SHALL drive sig_out = idle_level whenever in IDLE, tracking idle_level with one-cycle registered latency.
REQ-024 SHALL, when en is low at an edge, clear the buffer, enter IDLE, drive sig_out = idle_level and busy = 0, without asserting done.
REQ-025 SHALL keep busy = 1 for every cycle sig_out carries a symbol, including across reloads.
REQ-026 SHALL use saturation-free counters sized DUR_W and PRE_W; dur = all-ones SHALL give 2^DUR_W units without wrap error.

Reset
REQ-027 SHALL, when sys_rst is high at an edge, set sig_out = 0, busy = 0, done = 0, buffer empty, state IDLE, all counters 0.
REQ-028 SHALL give sys_rst priority over en and over any handshake on the same edge; a mid-symbol reset SHALL truncate the symbol immediately.
REQ-029 SHALL hold sym_ready low while sys_rst is high.

Configuration
REQ-030 SHALL, with PULSE_CARRIER_EN defined, add input carrier_half (8 bits) and, while a level-1 symbol is active, toggle sig_out every carrier_half+1 clocks, starting high at each load, with the carrier counter restarting at each load.
REQ-031 SHALL, with PULSE_CARRIER_EN defined, leave level-0 symbols and IDLE output unmodulated.
REQ-032 SHALL, without PULSE_CARRIER_EN, omit carrier_half and drive sig_out = latched level during RUN.

Verification
REQ-033 Single symbol: prescale=2, level=1, dur=3, idle_level=0 -> sig_out high exactly 12 clocks starting at handshake edge +1; done pulses once at the end edge.
REQ-034 Back-to-back: symbols (1,dur=1),(0,dur=0),(1,dur=2), prescale=0, valid held -> sig_out 1,1,0,1,1,1 with no gaps; busy continuously high for 6 cycles; done once.
REQ-035 Abort: en dropped at clock 5 of a 20-clock symbol with buffer full -> sig_out = idle_level next edge, buffer empty, done never asserted.
REQ-036 Reset mid-symbol: sys_rst high during RUN with idle_level=1 -> sig_out=0, busy=0, sym_ready=0; first post-reset symbol timed correctly.
REQ-037 Boundary: dur=255, prescale=15 -> symbol lasts exactly 4096 clocks; prescale changed mid-symbol affects only the next symbol.
REQ-038 PULSE_CARRIER_EN: carrier_half=1, level-1 symbol of 8 clocks -> sig_out 1,1,0,0,1,1,0,0; level-0 symbol stays 0.

Source files
------------

// File: rtl/pulse_symbol_engine.sv
// Pulse symbol engine: one-entry symbol buffer feeding an IDLE/RUN emitter of timed levels.
// Optional carrier modulation of level-1 symbols when PULSE_CARRIER_EN is defined.
module pulse_symbol_engine #(
   parameter int DUR_W = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale,
   input  logic             idle_level,
   input  logic             sym_valid,
   input  logic             sym_level,
   input  logic [DUR_W-1:0] sym_dur,
`ifdef PULSE_CARRIER_EN
   input  logic [7:0]       carrier_half,
`endif
   output logic             sym_ready,
   output logic             sig_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic             buf_full;
   logic             buf_level;
   logic [DUR_W-1:0] buf_dur;
   logic             cur_level;
   logic [DUR_W-1:0] dur_l;
   logic [DUR_W-1:0] dur_cnt;
   logic [PRE_W-1:0] pre_l;
   logic [PRE_W-1:0] pre_cnt;
`ifdef PULSE_CARRIER_EN
   logic [7:0]       car_cnt;
`endif

   logic accept;
   logic sym_end;

   assign sym_ready = en && !buf_full && !sys_rst;
   assign accept    = sym_valid && sym_ready;
   // Counters index the clock within the symbol, so the last clock is (dur, prescale).
   assign sym_end   = (state == RUN) && (pre_cnt == pre_l) && (dur_cnt == dur_l);

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         buf_full  <= 1'b0;
         buf_level <= 1'b0;
         buf_dur   <= '0;
         cur_level <= 1'b0;
         dur_l     <= '0;
         dur_cnt   <= '0;
         pre_l     <= '0;
         pre_cnt   <= '0;
         sig_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef PULSE_CARRIER_EN
         car_cnt   <= '0;
`endif
      end else if (!en) begin
         state    <= IDLE;
         buf_full <= 1'b0;
         sig_out  <= idle_level;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         // accept needs an empty buffer and a load needs a full one, so they never collide
         if (accept) begin
            buf_full  <= 1'b1;
            buf_level <= sym_level;
            buf_dur   <= sym_dur;
         end
         if (buf_full && (state == IDLE || sym_end)) begin
            state     <= RUN;
            buf_full  <= 1'b0;
            cur_level <= buf_level;
            dur_l     <= buf_dur;
            pre_l     <= prescale;
            dur_cnt   <= '0;
            pre_cnt   <= '0;
            sig_out   <= buf_level;
            busy      <= 1'b1;
`ifdef PULSE_CARRIER_EN
            car_cnt   <= '0;
`endif
         end else if (state == IDLE || sym_end) begin
            state   <= IDLE;
            sig_out <= idle_level;
            busy    <= 1'b0;
            done    <= sym_end;
         end else begin
            if (pre_cnt == pre_l) begin
               pre_cnt <= '0;
               dur_cnt <= dur_cnt + DUR_W'(1);
            end else begin
               pre_cnt <= pre_cnt + PRE_W'(1);
            end
`ifdef PULSE_CARRIER_EN
            if (cur_level) begin
               if (car_cnt == carrier_half) begin
                  car_cnt <= '0;
                  sig_out <= ~sig_out;
               end else begin
                  car_cnt <= car_cnt + 8'd1;
               end
            end else begin
               sig_out <= 1'b0;
            end
`else
            sig_out <= cur_level;
`endif
         end
      end
   end

endmodule
